multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 46 ++++
 rtl/mcctrl_outdec.sv | 90 +++++++++
 rtl/multicycle_control.sv | 108 ++++++++++
 tb/tb_multicycle_control.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - state encodings, opcodes and ALUOp codes shared by the control units
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    IMMEX  = 4'd8,
    IMMWB  = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] ORI   = 6'b001101;
  localparam logic [5:0] ANDI  = 6'b001100;
  localparam logic [5:0] SLTI  = 6'b001010;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  // ALU operation for the immediate-format instructions; addi is the fallback
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      ORI:     imm_aluop = ALU_OR;
      ANDI:    imm_aluop = ALU_AND;
      SLTI:    imm_aluop = ALU_SLT;
      default: imm_aluop = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mcctrl_outdec.sv
// rtl/mcctrl_outdec.sv - combinational state-to-strobe decoder for the multicycle control FSM
module mcctrl_outdec
  import multicycle_control_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic [2:0] alu_op_o
);

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    ir_write_o      = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    pc_source_o     = 2'b00;
    alu_op_o        = ALU_ADD;
    case (state_i)
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      DECODE: alu_src_b_o = 2'b11;
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      MEMRD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      MEMWR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      ALUWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      // the immediate ALU op is the only output that looks at the live opcode
      IMMEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = imm_aluop(opcode_i);
      end
      IMMWB: reg_write_o = 1'b1;
      BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 2'b01;
      end
      JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM; MCCTRL_PERF_EN adds the retired-instruction counter
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [2:0]         ALUOp,
  output logic               illegal,
`ifdef MCCTRL_PERF_EN
  output logic [31:0]        retired,
`endif
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = FETCH;
    illegal_d = 1'b0;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          LW, SW:                 state_d = MEMADR;
          RTYPE:                  state_d = (funct != 6'd0) ? EXEC : FETCH;
          ADDI, ORI, ANDI, SLTI:  state_d = IMMEX;
          BEQ:                    state_d = BRANCH;
          J:                      state_d = JUMP;
          default:                illegal_d = 1'b1;
        endcase
      end
      MEMADR: state_d = (opcode == SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      IMMEX:  state_d = IMMWB;
      default: state_d = FETCH;
    endcase
  end

  mcctrl_outdec u_outdec (
    .state_i         (state_q),
    .opcode_i        (opcode),
    .mem_ready_i     (mem_ready),
    .pc_write_o      (PCWrite),
    .pc_write_cond_o (PCWriteCond),
    .iord_o          (IorD),
    .ir_write_o      (IRWrite),
    .mem_read_o      (MemRead),
    .mem_write_o     (MemWrite),
    .mem_to_reg_o    (MemToReg),
    .reg_dst_o       (RegDst),
    .reg_write_o     (RegWrite),
    .alu_src_a_o     (ALUSrcA),
    .alu_src_b_o     (ALUSrcB),
    .pc_source_o     (PCSource),
    .alu_op_o        (ALUOp)
  );

  assign illegal = illegal_q;
  assign state   = STATE_W'(state_q);

`ifdef MCCTRL_PERF_EN
  logic [31:0] retired_q;
  logic        retire;

  // a nop leaves DECODE for FETCH without flagging illegal, so it retires too
  assign retire = (state_d == FETCH) &&
                  ((state_q inside {MEMWB, MEMWR, ALUWB, IMMWB, BRANCH, JUMP}) ||
                   (state_q == DECODE && !illegal_d));

  always_ff @(posedge clk) begin
    if (reset)       retired_q <= 32'd0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       reset, mem_ready;
  logic [5:0] opcode, funct;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;
`ifdef MCCTRL_PERF_EN
  logic [31:0] retired;
`endif

  always #5 clk = ~clk;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .illegal(illegal),
`ifdef MCCTRL_PERF_EN
    .retired(retired),
`endif
    .state(state)
  );

  logic [17:0] act_ctrl;
  assign act_ctrl = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  st;
    logic [17:0] ctrl;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    int          len;
    logic [19:0] path;
    logic        ill;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // expected strobes for each state, written straight from the state table
  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                           input logic mr, input logic ill);
    logic pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 3'b010; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin
        asa = 1; asb = 2'b10;
        aop = (op == 6'b001101) ? 3'b001 : (op == 6'b001100) ? 3'b011 :
              (op == 6'b001010) ? 3'b111 : 3'b000;
      end
      4'd9:  rw = 1;
      4'd10: begin asa = 1; aop = 3'b110; pcwc = 1; pcs = 2'b01; end
      4'd11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, asa, asb, pcs, aop, ill};
  endfunction

  function automatic vec_t mkv(input logic [5:0] op, input logic [5:0] fn, input int len,
                               input logic [19:0] path, input logic ill);
    vec_t v;
    v.op = op; v.fn = fn; v.len = len; v.path = path; v.ill = ill;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ill_pend;
    int   exp_ret;
    int   wr_cnt;
    logic rw_seen;
    exp_t e;
    logic [3:0] st;

    vecs[0]  = mkv(6'b100011, 6'b000000, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b0);
    vecs[1]  = mkv(6'b101011, 6'b000000, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 1'b0);
    vecs[2]  = mkv(6'b000000, 6'b100000, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 1'b0);
    vecs[3]  = mkv(6'b000000, 6'b000000, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 1'b0);
    vecs[4]  = mkv(6'b001000, 6'b000000, 4, {4'd0, 4'd9, 4'd8, 4'd1, 4'd0}, 1'b0);
    vecs[5]  = mkv(6'b001101, 6'b000000, 4, {4'd0, 4'd9, 4'd8, 4'd1, 4'd0}, 1'b0);
    vecs[6]  = mkv(6'b001100, 6'b000000, 4, {4'd0, 4'd9, 4'd8, 4'd1, 4'd0}, 1'b0);
    vecs[7]  = mkv(6'b001010, 6'b000000, 4, {4'd0, 4'd9, 4'd8, 4'd1, 4'd0}, 1'b0);
    vecs[8]  = mkv(6'b000100, 6'b000000, 3, {4'd0, 4'd0, 4'd10, 4'd1, 4'd0}, 1'b0);
    vecs[9]  = mkv(6'b000010, 6'b000000, 3, {4'd0, 4'd0, 4'd11, 4'd1, 4'd0}, 1'b0);
    vecs[10] = mkv(6'b111111, 6'b000000, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 1'b1);
    vecs[11] = mkv(6'b100011, 6'b000000, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b0);

    reset = 1'b1; opcode = 6'd0; funct = 6'd0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_ctrl", 32'(act_ctrl), 32'(exp_ctrl(4'd0, 6'd0, 1'b1, 1'b0)));
`ifdef MCCTRL_PERF_EN
    chk("reset_retired", retired, 32'd0);
`endif

    ill_pend = 1'b0;
    exp_ret  = 0;
    foreach (vecs[v]) begin
      opcode = vecs[v].op;
      funct  = vecs[v].fn;
      for (int i = 0; i < vecs[v].len; i++) begin
        st = vecs[v].path[i*4 +: 4];
        sb.push_back('{st, exp_ctrl(st, vecs[v].op, 1'b1, (i == 0) && ill_pend)});
      end
      ill_pend = vecs[v].ill;
      if (!vecs[v].ill) exp_ret++;
      for (int i = 0; i < vecs[v].len; i++) begin
        #1;
        e = sb.pop_front();
        chk($sformatf("vec%0d_cyc%0d_state", v, i), 32'(state), 32'(e.st));
        chk($sformatf("vec%0d_cyc%0d_ctrl", v, i), 32'(act_ctrl), 32'(e.ctrl));
        adv();
      end
    end
    #1;
    chk("table_end_state", 32'(state), 32'd0);
    chk("table_end_ctrl", 32'(act_ctrl), 32'(exp_ctrl(4'd0, opcode, 1'b1, ill_pend)));
`ifdef MCCTRL_PERF_EN
    chk("table_retired", retired, 32'(exp_ret));
`endif

    // sw: fetch stalls, then three MEMWR wait cycles
    opcode = SW; mem_ready = 1'b0;
    adv();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("fetch_stall%0d_state", k), 32'(state), 32'd0);
      chk($sformatf("fetch_stall%0d_pcw_irw", k), {30'd0, PCWrite, IRWrite}, 32'd0);
      adv();
    end
    mem_ready = 1'b1;
    #1;
    chk("fetch_go_pcw_irw", {30'd0, PCWrite, IRWrite}, 32'd3);
    adv(); adv(); adv();
    mem_ready = 1'b0; wr_cnt = 0; rw_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("memwr_wait%0d_state", k), 32'(state), 32'd5);
      wr_cnt += int'(MemWrite); rw_seen |= RegWrite;
      adv();
    end
    mem_ready = 1'b1;
    #1;
    chk("memwr_last_state", 32'(state), 32'd5);
    wr_cnt += int'(MemWrite); rw_seen |= RegWrite;
    adv();
    #1;
    chk("sw_done_state", 32'(state), 32'd0);
    chk("sw_memwrite_cycles", 32'(wr_cnt), 32'd4);
    chk("sw_no_regwrite", 32'(rw_seen), 32'd0);

    // R-type: opcode changes during EXEC must not redirect the FSM
    opcode = RTYPE; funct = 6'b100000;
    adv(); adv();
    #1;
    chk("exec_state", 32'(state), 32'd6);
    chk("exec_aluop", 32'(ALUOp), 32'd2);
    opcode = LW; funct = 6'd0;
    adv();
    chk("aluwb_state", 32'(state), 32'd7);
    chk("aluwb_regdst_regwrite", {30'd0, RegDst, RegWrite}, 32'd3);
    adv();
    chk("rtype_done_state", 32'(state), 32'd0);

    // reset in the middle of a MEMRD wait
    opcode = LW;
    adv(); adv();
    mem_ready = 1'b0;
    adv(); adv();
    chk("memrd_wait_state", 32'(state), 32'd3);
    reset = 1'b1;
    adv();
    reset = 1'b0;
    chk("rst_memrd_state", 32'(state), 32'd0);
    chk("rst_memrd_mread_iord", {30'd0, MemRead, IorD}, 32'd2);
    chk("rst_memrd_illegal", 32'(illegal), 32'd0);
`ifdef MCCTRL_PERF_EN
    chk("rst_memrd_retired", retired, 32'd0);
`endif

    // five back-to-back addi instructions
    mem_ready = 1'b1; opcode = ADDI;
    repeat (20) adv();
    chk("addi5_state", 32'(state), 32'd0);
`ifdef MCCTRL_PERF_EN
    chk("addi5_retired", retired, 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
